// File: rtl/filter_pkg.sv
// Shared spatial-filter helpers: width derivation and output saturation.
package filter_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int prod_width(input int pix_bit, input int cof_bit);
        return pix_bit + cof_bit + 1;
    endfunction

    function automatic int sum_width(input int prod_w, input int terms);
        return prod_w + clog2(terms);
    endfunction

    // Clip a scaled sum into the signed pix_bit+1 output range.
    function automatic logic signed [63:0] sat_q(
        input logic signed [63:0] shifted,
        input int                 pix_bit
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< pix_bit) - 64'sd1;
        lo = -(64'sd1 <<< pix_bit);
        if (shifted > hi) r = hi;
        else if (shifted < lo) r = lo;
        else r = shifted;
        return r;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered reduction level: N inputs of width W to N/2 pairwise sums.
module adder_tree_level
    import filter_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [N*W-1:0]   d,
    output logic [N/2*W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (ce) begin
            for (int i = 0; i < N / 2; i++)
                q[i*W +: W] <= d[2*i*W +: W] + d[(2*i+1)*W +: W];
        end
    end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree with scaling, saturation and sat counter.
// Optional round-half-up before the shift: define ADDER_TREE_ROUND_EN.
module adder_tree_pipe
    import filter_pkg::*;
#(
    parameter int PIX_BIT    = 8,
    parameter int COFCNT_BIT = 15,
    parameter int TERM_SIZE  = 49,
    parameter int FRAC_SHIFT = 15,
    parameter int SATCNT_BIT = 16,
    localparam int PROD_W    = prod_width(PIX_BIT, COFCNT_BIT)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ce,
    input  logic                        in_valid,
    input  logic [PROD_W*TERM_SIZE-1:0] term_in,
    input  logic                        sat_clr,
    output logic [PIX_BIT:0]            q,
    output logic                        out_valid,
    output logic                        sat,
    output logic [SATCNT_BIT-1:0]       sat_cnt
);

    localparam int LEVELS   = clog2(TERM_SIZE);
    localparam int PAD_SIZE = 1 << LEVELS;
    localparam int SUM_W    = sum_width(PROD_W, TERM_SIZE);
    localparam int NODES    = 2 * PAD_SIZE - 1;

    // Heap layout: level l starts at node 2*PAD_SIZE - 2*(PAD_SIZE>>l).
    logic [NODES*SUM_W-1:0]     tree;
    logic [TERM_SIZE*SUM_W-1:0] stage0;
    logic [LEVELS:0]            vpipe;
    logic signed [SUM_W-1:0]    sum;
    logic signed [63:0]         shifted;
    logic signed [63:0]         clipped;
    logic                       sat_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage0 <= '0;
            vpipe  <= '0;
        end else if (ce) begin
            for (int k = 0; k < TERM_SIZE; k++)
                stage0[k*SUM_W +: SUM_W] <=
                    SUM_W'($signed(term_in[k*PROD_W +: PROD_W]));
            vpipe <= {vpipe[LEVELS-1:0], in_valid};
        end
    end

    assign tree[0 +: TERM_SIZE*SUM_W] = stage0;

    if (PAD_SIZE > TERM_SIZE) begin : g_pad
        assign tree[TERM_SIZE*SUM_W +: (PAD_SIZE-TERM_SIZE)*SUM_W] = '0;
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N  = PAD_SIZE >> l;
        localparam int IO = 2 * PAD_SIZE - 2 * N;
        localparam int OO = 2 * PAD_SIZE - N;
        adder_tree_level #(
            .N(N),
            .W(SUM_W)
        ) u_lvl (
            .clk  (clk),
            .reset(reset),
            .ce   (ce),
            .d    (tree[IO*SUM_W +: N*SUM_W]),
            .q    (tree[OO*SUM_W +: N/2*SUM_W])
        );
    end

    assign sum = tree[(NODES-1)*SUM_W +: SUM_W];

`ifdef ADDER_TREE_ROUND_EN
    localparam logic [SUM_W:0] RND = ((SUM_W+1)'(1) << FRAC_SHIFT) >> 1;
    logic signed [SUM_W:0] rsum;
    assign rsum    = $signed({sum[SUM_W-1], sum}) + $signed(RND);
    assign shifted = 64'(rsum >>> FRAC_SHIFT);
`else
    assign shifted = 64'(sum >>> FRAC_SHIFT);
`endif

    assign clipped = sat_q(shifted, PIX_BIT);
    assign sat_n   = (clipped != shifted);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q         <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else if (ce) begin
            q         <= clipped[PIX_BIT:0];
            sat       <= sat_n;
            out_valid <= vpipe[LEVELS];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sat_cnt <= '0;
        else if (sat_clr)
            sat_cnt <= '0;
        else if (ce && vpipe[LEVELS] && sat_n && (sat_cnt != '1))
            sat_cnt <= sat_cnt + SATCNT_BIT'(1);
    end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench: default 49-tap tree plus a small 8-tap, 2-bit-counter tree.
module tb_adder_tree_pipe;

    localparam int TS = 49;
    localparam int PW = 24;
    localparam int FS = 15;
    localparam int LAT = 8;
    localparam int TS2 = 8;

    typedef struct {
        logic [8:0] q;
        bit         sat;
        longint     idx;
    } exp_t;

    logic clk = 0;
    logic reset = 1;
    logic ce = 1;
    logic in_valid = 0;
    logic [PW*TS-1:0] term_in = '0;
    logic sat_clr = 0;
    logic [8:0] q;
    logic out_valid;
    logic sat;
    logic [15:0] sat_cnt;

    logic ce2 = 1;
    logic in_valid2 = 0;
    logic [PW*TS2-1:0] term2 = '0;
    logic sat_clr2 = 0;
    logic [8:0] q2;
    logic out_valid2;
    logic sat2;
    logic [1:0] sat_cnt2;

    int checks = 0;
    int errors = 0;
    longint en_edges = 0;
    longint cnt_model = 0;
    longint cur[TS];
    exp_t sb[$];

    always #5 clk = ~clk;

    adder_tree_pipe dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .term_in(term_in), .sat_clr(sat_clr), .q(q),
        .out_valid(out_valid), .sat(sat), .sat_cnt(sat_cnt)
    );

    adder_tree_pipe #(
        .PIX_BIT(8), .COFCNT_BIT(15), .TERM_SIZE(TS2),
        .FRAC_SHIFT(0), .SATCNT_BIT(2)
    ) dut2 (
        .clk(clk), .reset(reset), .ce(ce2), .in_valid(in_valid2),
        .term_in(term2), .sat_clr(sat_clr2), .q(q2),
        .out_valid(out_valid2), .sat(sat2), .sat_cnt(sat_cnt2)
    );

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic exp_t ref_out();
        exp_t e;
        longint s;
        s = 0;
        for (int i = 0; i < TS; i++) s += cur[i];
`ifdef ADDER_TREE_ROUND_EN
        s += 64'sd1 <<< (FS - 1);
`endif
        s = s >>> FS;
        e.sat = 0;
        if (s > 255) begin s = 255; e.sat = 1; end
        if (s < -256) begin s = -256; e.sat = 1; end
        e.q = 9'(s);
        e.idx = 0;
        return e;
    endfunction

    function automatic longint rand_term();
        logic signed [23:0] t24;
        longint r;
        case ($urandom_range(0, 3))
            0: r = longint'($urandom_range(0, 1 << 17)) - (1 << 16);
            1: begin t24 = 24'($urandom); r = longint'(t24); end
            2: r = 0;
            default: r = longint'($urandom_range(0, 1 << 15));
        endcase
        return r;
    endfunction

    task automatic issue();
        exp_t e;
        @(negedge clk);
        ce = 1;
        in_valid = 1;
        for (int i = 0; i < TS; i++) term_in[i*PW +: PW] = PW'(cur[i]);
        e = ref_out();
        e.idx = en_edges;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ce = 1;
            in_valid = 0;
        end
    endtask

    task automatic stall(input int n);
        repeat (n) begin
            @(negedge clk);
            ce = 0;
            in_valid = 1;
            for (int i = 0; i < TS; i++) term_in[i*PW +: PW] = PW'(rand_term());
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            ce = 1;
            in_valid = 0;
            n++;
        end
        chk(name, longint'(sb.size()), 0);
    endtask

    task automatic fill(input longint v);
        for (int i = 0; i < TS; i++) cur[i] = v;
    endtask

    // Monitor: compares every fresh output against the scoreboard head.
    initial begin
        bit en;
        exp_t e;
        forever begin
            @(posedge clk);
            en = ce && !reset;
            if (en) en_edges++;
            #1;
            if (en && out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("q", longint'(q), longint'(e.q));
                    chk("sat", longint'(sat), longint'(e.sat));
                    chk("latency", en_edges - e.idx, LAT);
                    if (e.sat && cnt_model < 65535) cnt_model++;
                    chk("sat_cnt", longint'(sat_cnt), cnt_model);
                end
            end
        end
    end

    initial begin
        #1;
        chk("rst_q", longint'(q), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_sat", longint'(sat), 0);
        chk("rst_sat_cnt", longint'(sat_cnt), 0);
        repeat (2) @(negedge clk);
        reset = 0;

        fill(1 << 15);
        issue();
        drain("drain_ones");
        @(posedge clk);
        #1;
        chk("out_valid_drop", longint'(out_valid), 0);

        fill(255 << 15);
        issue();
        fill(-(10 << 15));
        issue();
        fill(0);
        cur[0] = 'h4000;
        issue();
        cur[0] = -'h4000;
        issue();
        drain("drain_directed");

        for (int k = 0; k < 20; k++) begin
            if (k == 10) stall(3);
            fill(0);
            cur[0] = longint'(k) << 15;
            issue();
        end
        drain("drain_stream");

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < TS; i++) cur[i] = rand_term();
            issue();
        end
        @(posedge clk);
        #3;
        reset = 1;
        #1;
        chk("arst_q", longint'(q), 0);
        chk("arst_out_valid", longint'(out_valid), 0);
        chk("arst_sat", longint'(sat), 0);
        chk("arst_sat_cnt", longint'(sat_cnt), 0);
        sb.delete();
        cnt_model = 0;
        in_valid = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        idle(15);

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 9) == 0) stall($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
            for (int i = 0; i < TS; i++) cur[i] = rand_term();
            issue();
        end
        drain("drain_random");

        @(negedge clk);
        in_valid2 = 1;
        for (int i = 0; i < TS2; i++) term2[i*PW +: PW] = PW'(i + 1);
        @(negedge clk);
        in_valid2 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("t8_early", longint'(out_valid2), 0);
        @(posedge clk);
        #1;
        chk("t8_valid", longint'(out_valid2), 1);
        chk("t8_q", longint'(q2), 36);
        chk("t8_sat", longint'(sat2), 0);
        @(posedge clk);
        #1;
        chk("t8_valid_drop", longint'(out_valid2), 0);

        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            in_valid2 = 1;
            for (int i = 0; i < TS2; i++) term2[i*PW +: PW] = PW'(100);
        end
        @(negedge clk);
        in_valid2 = 0;
        @(posedge clk);
        #1;
        chk("cnt2_first", longint'(sat_cnt2), 1);
        chk("q2_clip", longint'(q2), 255);
        chk("sat2", longint'(sat2), 1);
        repeat (2) @(posedge clk);
        #1;
        chk("cnt2_max", longint'(sat_cnt2), 3);
        @(posedge clk);
        #1;
        chk("cnt2_stick", longint'(sat_cnt2), 3);

        @(negedge clk);
        in_valid2 = 1;
        @(negedge clk);
        in_valid2 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sat_clr2 = 1;
        @(posedge clk);
        #1;
        chk("clr_sat_flag", longint'(sat2 & out_valid2), 1);
        chk("clr_priority", longint'(sat_cnt2), 0);
        @(negedge clk);
        sat_clr2 = 0;

        @(negedge clk);
        in_valid2 = 1;
        @(negedge clk);
        in_valid2 = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("cnt2_after_clr", longint'(sat_cnt2), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
